// File: rtl/dmem_responder.sv
// Single-port data-memory responder for the pipeline MEM stage: IDLE -> WAIT -> RESP
// handshake with a fixed number of wait states; all outputs come straight from flops.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_next;
  logic [2:0]  cnt, cnt_next;
  logic        accept;
  logic        we_q;
  logic [31:0] addr_q, wdata_q;

  logic        acc_we;
  logic [31:0] acc_addr, acc_wdata;
  logic        acc_fault;
  logic [AW-1:0] acc_idx;
  logic        enter_resp;

  logic [31:0] mem [DEPTH_WORDS];

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (LATENCY == 0) begin
            state_next = RESP;
            cnt_next   = '0;
          end else begin
            state_next = WAIT;
            cnt_next   = 3'(LATENCY);
          end
        end
      end
      WAIT: begin
        if (cnt == 3'd1) begin
          state_next = RESP;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt - 3'd1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // With zero wait states RESP is entered on the accepting edge, so the access
  // must be taken from the live inputs rather than the (not yet loaded) latches.
  always_comb begin
    acc_we     = (state == IDLE) ? we    : we_q;
    acc_addr   = (state == IDLE) ? addr  : addr_q;
    acc_wdata  = (state == IDLE) ? wdata : wdata_q;
    acc_fault  = (acc_addr[1:0] != 2'b00) ||
                 ({2'b00, acc_addr[31:2]} >= 32'(DEPTH_WORDS));
    acc_idx    = acc_addr[AW+1:2];
    enter_resp = (state_next == RESP);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy    <= 1'b0;
      ack     <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      busy  <= (state_next != IDLE);
      ack   <= enter_resp;
      err   <= enter_resp && acc_fault;
      rdata <= (enter_resp && !acc_we && !acc_fault) ? mem[acc_idx] : '0;
    end
  end

  // Storage is deliberately not reset; a reset edge in WAIT suppresses the commit.
  always_ff @(posedge clk) begin
    if (reset && enter_resp && acc_we && !acc_fault)
      mem[acc_idx] <= acc_wdata;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances (LATENCY 2, 0, 7) sharing clock,
// reset and access inputs, each with its own req.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [31:0] addr, wdata;
  logic [2:0]  req_v, busy_v, ack_v, err_v;
  logic [31:0] rdata_v [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut_l2 (
    .clk(clk), .reset(reset), .req(req_v[0]), .we(we), .addr(addr), .wdata(wdata),
    .busy(busy_v[0]), .ack(ack_v[0]), .rdata(rdata_v[0]), .err(err_v[0]));

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) dut_l0 (
    .clk(clk), .reset(reset), .req(req_v[1]), .we(we), .addr(addr), .wdata(wdata),
    .busy(busy_v[1]), .ack(ack_v[1]), .rdata(rdata_v[1]), .err(err_v[1]));

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(7)) dut_l7 (
    .clk(clk), .reset(reset), .req(req_v[2]), .we(we), .addr(addr), .wdata(wdata),
    .busy(busy_v[2]), .ack(ack_v[2]), .rdata(rdata_v[2]), .err(err_v[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drives one access in the current cycle, churns the shared inputs after acceptance,
  // and checks busy/ack per cycle, the response, and the return to idle.
  task automatic access(input string tag, input int s, input int lat, input logic w,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input logic exp_err);
    we = w; addr = a; wdata = d; req_v[s] = 1'b1;
    for (int i = 1; i <= lat + 1; i++) begin
      cyc();
      if (i == 1) begin
        req_v[s] = 1'b0; we = ~w; addr = ~a; wdata = ~d;
      end
      check({tag, "_busy"}, 32'(busy_v[s]), 32'd1);
      check({tag, "_ack"},  32'(ack_v[s]),  32'(i == lat + 1));
    end
    check({tag, "_rdata"}, rdata_v[s], exp_rd);
    check({tag, "_err"},   32'(err_v[s]), 32'(exp_err));
    cyc();
    check({tag, "_ack_off"},   32'(ack_v[s]),  32'd0);
    check({tag, "_busy_off"},  32'(busy_v[s]), 32'd0);
    check({tag, "_rdata_off"}, rdata_v[s], 32'd0);
    check({tag, "_err_off"},   32'(err_v[s]), 32'd0);
  endtask

  initial begin
    reset = 1'b0; req_v = '0; we = 1'b0; addr = '0; wdata = '0;
    repeat (3) cyc();
    check("rst_busy",  32'(busy_v), 32'd0);
    check("rst_ack",   32'(ack_v),  32'd0);
    check("rst_err",   32'(err_v),  32'd0);
    check("rst_rdata", rdata_v[0],  32'd0);

    // Request on the first edge with reset released
    reset = 1'b1;
    access("st10", 0, 2, 1'b1, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0);
    access("ld10", 0, 2, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);

    access("st0",    0, 2, 1'b1, 32'h0,   32'h11112222, 32'd0, 1'b0);
    access("ld12",   0, 2, 1'b0, 32'h12,  32'd0,        32'd0, 1'b1);
    access("st400",  0, 2, 1'b1, 32'h400, 32'h00000BAD, 32'd0, 1'b1);
    access("st3",    0, 2, 1'b1, 32'h3,   32'h33333333, 32'd0, 1'b1);
    access("ld0",    0, 2, 1'b0, 32'h0,   32'd0, 32'h11112222, 1'b0);
    access("st3fc",  0, 2, 1'b1, 32'h3FC, 32'hCAFEF00D, 32'd0, 1'b0);
    access("ld3fc",  0, 2, 1'b0, 32'h3FC, 32'd0, 32'hCAFEF00D, 1'b0);
    access("ldbig",  0, 2, 1'b0, 32'h8000_0000, 32'd0, 32'd0, 1'b1);

    // Held request: accepted in cycles 0, 4, 8
    we = 1'b0; addr = 32'h10; req_v[0] = 1'b1;
    check("held_busy_c0", 32'(busy_v[0]), 32'd0);
    for (int c = 1; c <= 12; c++) begin
      cyc();
      if (c == 10) req_v[0] = 1'b0;
      check($sformatf("held_busy_c%0d", c), 32'(busy_v[0]), 32'((c % 4) != 0));
      check($sformatf("held_ack_c%0d", c),  32'(ack_v[0]),  32'((c % 4) == 3));
      check($sformatf("held_rd_c%0d", c),   rdata_v[0],
            ((c % 4) == 3) ? 32'hDEADBEEF : 32'd0);
    end

    // Reset during WAIT aborts the store
    access("st20", 0, 2, 1'b1, 32'h20, 32'h00000077, 32'd0, 1'b0);
    we = 1'b1; addr = 32'h20; wdata = 32'h55; req_v[0] = 1'b1;
    cyc();
    req_v[0] = 1'b0;
    cyc();
    reset = 1'b0;
    cyc();
    check("rstw_busy", 32'(busy_v[0]), 32'd0);
    check("rstw_ack",  32'(ack_v[0]),  32'd0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("rstw_noack", 32'(ack_v[0]), 32'd0);
    end
    access("ld20", 0, 2, 1'b0, 32'h20, 32'd0, 32'h00000077, 1'b0);

    // Reset during RESP: ack cut next cycle, committed store kept
    we = 1'b1; addr = 32'h24; wdata = 32'h99; req_v[0] = 1'b1;
    cyc();
    req_v[0] = 1'b0;
    cyc(); cyc();
    check("rstr_ack_now", 32'(ack_v[0]), 32'd1);
    reset = 1'b0;
    cyc();
    check("rstr_ack_next",  32'(ack_v[0]),  32'd0);
    check("rstr_busy_next", 32'(busy_v[0]), 32'd0);
    reset = 1'b1;
    access("ld24",    0, 2, 1'b0, 32'h24, 32'd0, 32'h99, 1'b0);
    access("ld10_kept", 0, 2, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);

    // Zero and maximum wait states
    access("l0_st8", 1, 0, 1'b1, 32'h8, 32'h12345678, 32'd0, 1'b0);
    access("l0_ld8", 1, 0, 1'b0, 32'h8, 32'd0, 32'h12345678, 1'b0);
    access("l0_ld9", 1, 0, 1'b0, 32'h9, 32'd0, 32'd0, 1'b1);
    access("l7_st4", 2, 7, 1'b1, 32'h4, 32'hA5A5F00F, 32'd0, 1'b0);
    access("l7_ld4", 2, 7, 1'b0, 32'h4, 32'd0, 32'hA5A5F00F, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit words in the storage array (power of two, 16..4096).
REQ-002 SHALL have parameter LATENCY, default 2, wait-state cycles per access (0..7).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port req  input  1  access request from the pipeline MEM stage.
REQ-006 SHALL have port we  input  1  1 = store, 0 = load; sampled with req.
REQ-007 SHALL have port addr  input  32  byte address; sampled with req.
REQ-008 SHALL have port wdata  input  32  store data; sampled with req.
REQ-009 SHALL have port busy  output  1  access in progress; the pipeline stalls while high.
REQ-010 SHALL have port ack  output  1  one-cycle completion pulse.
REQ-011 SHALL have port rdata  output  32  load data, valid only while ack=1.
REQ-012 SHALL have port err  output  1  access fault flag, valid only while ack=1.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-014 IDLE: req=1 at a rising edge SHALL latch we/addr/wdata and go to WAIT with counter=LATENCY, or straight to RESP if LATENCY=0.
REQ-015 WAIT SHALL decrement the counter once per cycle and go to RESP on the edge where the counter is 1.
REQ-016 RESP SHALL last exactly one cycle with ack=1, then return to IDLE unconditionally.
REQ-017 Timing: req sampled high in cycle t SHALL give busy=1 in cycles t+1..t+1+LATENCY and ack=1 only in cycle t+1+LATENCY.
REQ-018 req, we, addr and wdata SHALL be ignored whenever the state is not IDLE, including the ack cycle; a held req is accepted in the next IDLE cycle.
REQ-019 Fault: addr[1:0]!=0 or addr[31:2]>=DEPTH_WORDS SHALL set err=1 in the ack cycle and return rdata=0; a faulting store SHALL NOT modify the array.
REQ-020 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2].
REQ-021 A valid store SHALL commit to the array on the edge entering RESP; rdata SHALL be 0 in the ack cycle of a store.
REQ-022 A valid load SHALL register the array word on the edge entering RESP and SHALL present it on rdata during the ack cycle.
REQ-023 A load that follows a store to the same address SHALL return the newly stored value.
REQ-024 Outside the ack cycle, rdata and err SHALL be 0.
REQ-025 All outputs SHALL be driven from registers, with no combinational path from any input to any output.

Reset
REQ-026 When reset=0 at a rising edge, the block SHALL enter IDLE with busy=0, ack=0, err=0, rdata=0 and counter=0.
REQ-027 Reset asserted in WAIT SHALL abort the access with no array write and no ack.
REQ-028 Reset asserted in RESP SHALL suppress ack from the next cycle onward; a store already committed SHALL remain.
REQ-029 Array contents SHALL NOT be cleared by reset.
REQ-030 req sampled on the first edge with reset=1 SHALL be accepted normally.

Verification (LATENCY=2, DEPTH_WORDS=256 unless stated)
REQ-031 Store then load: store 0xDEADBEEF to 0x10 in cycle 0, then load 0x10 -> store ack in cycle 3, load ack 3 cycles after its request, rdata=0xDEADBEEF, err=0.
REQ-032 Misalign and range: load 0x12 -> ack with err=1 and rdata=0; store 0x400 -> err=1; a later load of word 0 returns its prior value.
REQ-033 Held req: req held high for 10 cycles -> accepted in cycles 0, 4 and 8; exactly one ack per 4 cycles; busy low only in the acceptance cycles.
REQ-034 LATENCY=0: req in cycle t -> busy=1 and ack=1 both in cycle t+1 only; LATENCY=7: ack in cycle t+8.
REQ-035 Reset mid-op: store 0x55 to 0x20, reset=0 in cycle t+2 (WAIT) -> no ack, busy=0 after the reset edge, a later load of 0x20 returns the old value.
REQ-036 Input churn: change addr/wdata during WAIT -> the access uses the values latched at acceptance.
